// File: rtl/twowayhandshake_recorder.sv
// Inline recorder for one valid/ready channel: emits logb/loge packets into a
// 2-entry skid buffer and stalls the channel rather than lose an event.
module twowayhandshake_recorder #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic                  logb_valid,
  output logic [DATA_WIDTH-1:0] logb_data,
  output logic                  loge_valid,
  output logic [CNT_WIDTH-1:0]  rec_logb_cnt,
  output logic [CNT_WIDTH-1:0]  rec_loge_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic                  space_q, space_d;
  logic                  pend_b_q, pend_b_d;
  logic                  loge_pend_q, loge_pend_d;
  logic                  o_b_q, o_b_d, o_e_q, o_e_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  r_b_q, r_b_d, r_e_q, r_e_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [CNT_WIDTH-1:0]  cnt_b_q, cnt_b_d, cnt_e_q, cnt_e_d;

  logic                  allow_new, fire, new_b, enq, deq;
  logic                  pkt_b, pkt_e;
  logic [DATA_WIDTH-1:0] pkt_data;

  always_comb begin
    allow_new = space_q && !loge_pend_q;
    out_valid = in_valid && (pend_b_q || allow_new);
    out_data  = in_data;
    fire      = out_valid && out_ready;
    in_ready  = fire;
    new_b     = out_valid && !pend_b_q;

    pkt_b     = new_b;
    pkt_data  = new_b ? in_data : '0;
    pkt_e     = fire || loge_pend_q;
    enq       = (new_b || fire || loge_pend_q) && space_q;

    // The unused encoding reads as EMPTY so it can never present a packet.
    log_valid = (state_q == BUSY) || (state_q == FULL);
    deq       = log_valid && log_ready;

    state_d  = state_q;
    o_b_d    = o_b_q;
    o_e_d    = o_e_q;
    o_data_d = o_data_q;
    r_b_d    = r_b_q;
    r_e_d    = r_e_q;
    r_data_d = r_data_q;

    case (state_q)
      BUSY: begin
        if (enq && !deq) begin
          r_b_d    = pkt_b;
          r_e_d    = pkt_e;
          r_data_d = pkt_data;
          state_d  = FULL;
        end else if (enq && deq) begin
          o_b_d    = pkt_b;
          o_e_d    = pkt_e;
          o_data_d = pkt_data;
        end else if (deq) begin
          o_b_d    = 1'b0;
          o_e_d    = 1'b0;
          o_data_d = '0;
          state_d  = EMPTY;
        end
      end
      FULL: begin
        // No enqueue is possible here because space is already low.
        if (deq) begin
          o_b_d    = r_b_q;
          o_e_d    = r_e_q;
          o_data_d = r_data_q;
          state_d  = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
        if (enq) begin
          o_b_d    = pkt_b;
          o_e_d    = pkt_e;
          o_data_d = pkt_data;
          state_d  = BUSY;
        end
      end
    endcase

    space_d = (state_d != FULL);

    loge_pend_d = loge_pend_q;
    if (enq && loge_pend_q) loge_pend_d = 1'b0;
    if (fire && !space_q)   loge_pend_d = 1'b1;

    pend_b_d = pend_b_q;
    if (fire)                         pend_b_d = 1'b0;
    else if (out_valid && !out_ready) pend_b_d = 1'b1;

    cnt_b_d = cnt_b_q;
    cnt_e_d = cnt_e_q;
    if (enq) begin
      cnt_b_d = cnt_b_q + {{(CNT_WIDTH-1){1'b0}}, pkt_b};
      cnt_e_d = cnt_e_q + {{(CNT_WIDTH-1){1'b0}}, pkt_e};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      space_q     <= 1'b0;
      pend_b_q    <= 1'b0;
      loge_pend_q <= 1'b0;
      o_b_q       <= 1'b0;
      o_e_q       <= 1'b0;
      o_data_q    <= '0;
      r_b_q       <= 1'b0;
      r_e_q       <= 1'b0;
      r_data_q    <= '0;
      cnt_b_q     <= '0;
      cnt_e_q     <= '0;
    end else begin
      state_q     <= state_d;
      space_q     <= space_d;
      pend_b_q    <= pend_b_d;
      loge_pend_q <= loge_pend_d;
      o_b_q       <= o_b_d;
      o_e_q       <= o_e_d;
      o_data_q    <= o_data_d;
      r_b_q       <= r_b_d;
      r_e_q       <= r_e_d;
      r_data_q    <= r_data_d;
      cnt_b_q     <= cnt_b_d;
      cnt_e_q     <= cnt_e_d;
    end
  end

  assign logb_valid   = o_b_q;
  assign logb_data    = o_data_q;
  assign loge_valid   = o_e_q;
  assign rec_logb_cnt = cnt_b_q;
  assign rec_loge_cnt = cnt_e_q;

endmodule

// File: tb/tb_twowayhandshake_recorder.sv
// Bench for twowayhandshake_recorder: directed scenarios plus randomized traffic
// compared against a queue-based reference of the recording rules.
module tb_twowayhandshake_recorder;
  localparam int DW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          log_valid, log_ready = 1'b0;
  logic          logb_valid, loge_valid;
  logic [DW-1:0] logb_data;
  logic [CW-1:0] rec_logb_cnt, rec_loge_cnt;

  twowayhandshake_recorder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .log_valid(log_valid), .log_ready(log_ready),
    .logb_valid(logb_valid), .logb_data(logb_data), .loge_valid(loge_valid),
    .rec_logb_cnt(rec_logb_cnt), .rec_loge_cnt(rec_loge_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          b;
    logic [DW-1:0] d;
    logic          e;
  } pkt_t;

  pkt_t          mq[$];
  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] obs_q[$];
  int            tests = 0;
  int            fails = 0;
  bit            m_space, m_lp, m_pb, last_fire, track;
  logic [CW-1:0] m_cb, m_ce;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    m_space = 0; m_lp = 0; m_pb = 0; last_fire = 0;
    m_cb = '0; m_ce = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; out_ready = 0; log_ready = 0;
    rst = 1;
    #1;
    chk("rst_log_valid", log_valid, 0);
    chk("rst_logb_valid", logb_valid, 0);
    chk("rst_logb_data", logb_data, 0);
    chk("rst_loge_valid", loge_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cnt_b", rec_logb_cnt, 0);
    chk("rst_cnt_e", rec_loge_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    reset_model();
  endtask

  // One clock: drive, check against the reference, then advance the reference.
  task automatic cycle(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit lrdy);
    bit ov, fire, newb, deq, enq;
    pkt_t p, front;
    logic [CW-1:0] diff;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; log_ready = lrdy;
    #1;
    ov   = iv && (m_pb || (m_space && !m_lp));
    fire = ov && ordy;
    newb = ov && !m_pb;
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, fire);
    chk("out_data", out_data, id);
    chk("log_valid", log_valid, mq.size() != 0);
    front = (mq.size() != 0) ? mq[0] : '0;
    chk("logb_valid", logb_valid, front.b);
    chk("logb_data", logb_data, front.d);
    chk("loge_valid", loge_valid, front.e);
    chk("cnt_b", rec_logb_cnt, m_cb);
    chk("cnt_e", rec_loge_cnt, m_ce);
    diff = rec_logb_cnt - rec_loge_cnt;
    chk("invariant", diff <= 1, 1);
    if (track && log_valid && log_ready && logb_valid) obs_q.push_back(logb_data);
    @(posedge clk);
    deq = (mq.size() != 0) && lrdy;
    enq = (newb || fire || m_lp) && m_space;
    p.b = newb;
    p.d = newb ? id : '0;
    p.e = fire || m_lp;
    if (deq) void'(mq.pop_front());
    if (enq) begin
      mq.push_back(p);
      m_cb = m_cb + CW'(p.b);
      m_ce = m_ce + CW'(p.e);
    end
    if (enq && m_lp) m_lp = 0;
    if (fire && !m_space) m_lp = 1;
    if (fire) m_pb = 0;
    else if (ov && !ordy) m_pb = 1;
    m_space = (mq.size() != 2);
    if (track && fire) acc_q.push_back(id);
    last_fire = fire;
  endtask

  initial begin
    bit            iv;
    logic [DW-1:0] id;
    int            cyc;
    track = 0;
    reset_model();
    #1 rst = 1;
    do_reset();

    // Idle after reset: nothing offered, nothing recorded.
    repeat (3) cycle(0, '0, 0, 1);

    // Single immediate transfer.
    cycle(1, 12'h005, 1, 1);
    #1;
    chk("t2_cnt_b", rec_logb_cnt, 1);
    chk("t2_cnt_e", rec_loge_cnt, 1);
    cycle(0, '0, 1, 1);

    // Held offer: one logb, then one loge when it completes.
    repeat (3) cycle(1, 12'h00A, 0, 1);
    cycle(1, 12'h00A, 1, 1);
    repeat (3) cycle(0, '0, 1, 1);
    chk("t3_cnt_b", rec_logb_cnt, 2);
    chk("t3_cnt_e", rec_loge_cnt, 2);

    // Logging bus stalled until the buffer fills and a loge goes pending.
    do_reset();
    cycle(0, '0, 0, 0);
    cycle(1, 12'h001, 1, 0);
    cycle(1, 12'h002, 0, 0);
    cycle(1, 12'h002, 1, 0);
    cycle(1, 12'h003, 1, 0);
    repeat (3) cycle(1, 12'h003, 1, 1);
    repeat (4) cycle(0, '0, 1, 1);
    chk("t4_cnt_b", rec_logb_cnt, 3);
    chk("t4_cnt_e", rec_loge_cnt, 3);

    // Reset while full with a pending loge.
    cycle(1, 12'h011, 1, 0);
    cycle(1, 12'h022, 0, 0);
    cycle(1, 12'h022, 1, 0);
    do_reset();
    cycle(0, '0, 1, 1);
    cycle(1, 12'h077, 1, 1);
    cycle(0, '0, 1, 1);
    chk("t5_cnt_b", rec_logb_cnt, 1);
    chk("t5_cnt_e", rec_loge_cnt, 1);

    // Randomized traffic with backpressure on both sides.
    track = 1;
    acc_q.delete();
    obs_q.delete();
    iv = 0; id = '0; cyc = 0;
    while (acc_q.size() < 300 && cyc < 20000) begin
      if (!iv || last_fire) begin
        iv = ($urandom_range(0, 3) != 0);
        id = DW'($urandom);
      end
      cycle(iv, id, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      cyc++;
    end
    chk("rand_done", acc_q.size() >= 300, 1);
    repeat (10) cycle(0, '0, 1, 1);
    chk("rand_log_count", obs_q.size(), acc_q.size());
    for (int i = 0; i < acc_q.size() && i < obs_q.size(); i++) begin
      chk("rand_logb_seq", obs_q[i], acc_q[i]);
    end
    chk("rand_drained", log_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
